// File: rtl/shifter_pkg.sv
// Shared definitions for the multi-cycle shift/rotate unit: operation encodings and FSM states.
package shifter_pkg;

    localparam logic [2:0] MODE_PASS = 3'b000;
    localparam logic [2:0] MODE_LSL  = 3'b001;
    localparam logic [2:0] MODE_LSR  = 3'b010;
    localparam logic [2:0] MODE_ASR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    // Pass and the reserved codes never move bits, whatever amount is requested.
    function automatic logic mode_moves(input logic [2:0] mode);
        return (mode == MODE_LSL) || (mode == MODE_LSR) || (mode == MODE_ASR) ||
               (mode == MODE_ROL) || (mode == MODE_ROR);
    endfunction

endpackage

// File: rtl/shift_step.sv
// One-position shift/rotate of a word, returning the shifted word and the bit that left it.
module shift_step
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] data,
    input  logic [2:0]       mode,
    output logic [WIDTH-1:0] next_data_c,
    output logic             carry_c
);

    always_comb begin
        next_data_c = data;
        carry_c     = 1'b0;
        case (mode)
            MODE_LSL: begin
                next_data_c = {data[WIDTH-2:0], 1'b0};
                carry_c     = data[WIDTH-1];
            end
            MODE_LSR: begin
                next_data_c = {1'b0, data[WIDTH-1:1]};
                carry_c     = data[0];
            end
            MODE_ASR: begin
                next_data_c = {data[WIDTH-1], data[WIDTH-1:1]};
                carry_c     = data[0];
            end
            MODE_ROL: begin
                next_data_c = {data[WIDTH-2:0], data[WIDTH-1]};
                carry_c     = data[WIDTH-1];
            end
            MODE_ROR: begin
                next_data_c = {data[0], data[WIDTH-1:1]};
                carry_c     = data[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit: one bit position per clock behind a valid/ready handshake.
module seq_shifter
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_mode,
    input  logic [AMT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero
);

    state_e             state_q, state_d;
    logic [AMT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [2:0]         mode_q, mode_d;
    logic               carry_q, carry_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [WIDTH-1:0]   step_data;
    logic               step_carry;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .data        (data_q),
        .mode        (mode_q),
        .next_data_c (step_data),
        .carry_c     (step_carry)
    );

    // Next-state, counter and datapath update.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        mode_d      = mode_q;
        carry_d     = carry_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    data_d     = in_data;
                    mode_d     = in_mode;
                    carry_d    = 1'b0;
                    in_ready_d = 1'b0;
                    if (mode_moves(in_mode) && (in_amt != '0)) begin
                        cnt_d   = in_amt;
                        state_d = S_SHIFT;
                    end else begin
                        cnt_d       = '0;
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                data_d  = step_data;
                carry_d = step_carry;
                cnt_d   = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            mode_q      <= MODE_PASS;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            mode_q      <= mode_d;
            carry_q     <= carry_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = data_q;
    assign out_carry = carry_q;
    // Zero flag follows the result register directly.
    assign out_zero  = (data_q == '0);

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: directed vectors, back-pressure, mid-operation reset, random traffic.
module tb_seq_shifter;

    localparam int unsigned W  = 16;
    localparam int unsigned AW = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [2:0]    in_mode;
    logic [AW-1:0] in_amt;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_carry;
    logic          out_zero;

    int checks;
    int errors;

    seq_shifter #(
        .WIDTH (W),
        .AMT_W (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_amt(input logic [2:0] m, input logic [AW-1:0] a);
        return (m >= 3'd1 && m <= 3'd5) ? int'(a) : 0;
    endfunction

    // Whole-amount reference: {carry, result} from wide shifts of the operand.
    function automatic logic [W:0] ref_op(input logic [W-1:0] d, input logic [2:0] m,
                                          input logic [AW-1:0] a);
        int            n;
        logic [W:0]    t;
        logic [2*W-1:0] dd;
        logic [W-1:0]  r;
        n  = eff_amt(m, a);
        dd = {d, d};
        if (n == 0) return {1'b0, d};
        case (m)
            3'd1: begin t = {1'b0, d} << n; return t; end
            3'd2: begin t = {d, 1'b0} >> n; return {t[0], t[W:1]}; end
            3'd3: begin t = (W+1)'($signed({d, 1'b0}) >>> n); return {t[0], t[W:1]}; end
            3'd4: begin dd = dd << n; r = dd[2*W-1:W]; return {r[0], r}; end
            default: begin dd = dd >> n; r = dd[W-1:0]; return {r[W-1], r}; end
        endcase
    endfunction

    // Issue one request, check latency, result, hold behaviour and the return to idle.
    task automatic do_txn(input logic [W-1:0] d, input logic [2:0] m, input logic [AW-1:0] a,
                          input logic [W-1:0] exp_d, input logic exp_c, input int exp_lat,
                          input int hold, input string tag);
        int n;
        chk({tag, ":ready_idle"}, 32'(in_ready), 32'(1));
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        in_amt   = a;
        @(posedge clk); #1;
        in_data = W'($urandom);
        in_mode = 3'($urandom);
        in_amt  = AW'($urandom);
        chk({tag, ":ready_busy"}, 32'(in_ready), 32'(0));
        n = 0;
        while (out_valid !== 1'b1 && n <= int'(W) + 2) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ":latency"}, 32'(n), 32'(exp_lat));
        chk({tag, ":data"},  32'(out_data),  32'(exp_d));
        chk({tag, ":carry"}, 32'(out_carry), 32'(exp_c));
        chk({tag, ":zero"},  32'(out_zero),  32'(exp_d == '0));
        repeat (hold) begin
            @(posedge clk); #1;
            chk({tag, ":hold"}, 32'({out_valid, in_ready, out_data, out_carry, out_zero}),
                32'({1'b1, 1'b0, exp_d, exp_c, exp_d == '0}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ":valid_drop"}, 32'(out_valid), 32'(0));
        chk({tag, ":ready_back"}, 32'(in_ready), 32'(1));
    endtask

    initial begin
        logic [W:0]    r;
        logic [W-1:0]  rd;
        logic [2:0]    rm;
        logic [AW-1:0] ra;
        logic          seen;

        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = '0;
        in_amt    = '0;
        out_ready = 1'b0;

        #12;
        chk("reset_vals", 32'({in_ready, out_valid, out_data, out_carry, out_zero}),
            32'({1'b1, 1'b0, 16'h0000, 1'b0, 1'b1}));
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        do_txn(16'hF0CF, 3'b000, 4'd1, 16'hF0CF, 1'b0, 0, 0, "pass_a1");
        do_txn(16'hF0CF, 3'b001, 4'd1, 16'hE19E, 1'b1, 1, 0, "lsl_a1");
        do_txn(16'hF0CF, 3'b010, 4'd1, 16'h7867, 1'b1, 1, 0, "lsr_a1");
        do_txn(16'hF0CF, 3'b011, 4'd1, 16'hF867, 1'b1, 1, 0, "asr_a1");
        do_txn(16'hF0CF, 3'b100, 4'd1, 16'hE19F, 1'b1, 1, 0, "rol_a1");
        do_txn(16'hF0CF, 3'b101, 4'd1, 16'hF867, 1'b1, 1, 0, "ror_a1");
        do_txn(16'hF0CF, 3'b001, 4'd4, 16'h0CF0, 1'b1, 4, 0, "lsl_a4");
        do_txn(16'hF0CF, 3'b101, 4'd4, 16'hFF0C, 1'b1, 4, 0, "ror_a4");
        do_txn(16'hF0CF, 3'b011, 4'd15, 16'hFFFF, 1'b1, 15, 0, "asr_a15");
        do_txn(16'h0001, 3'b010, 4'd1, 16'h0000, 1'b1, 1, 0, "lsr_to_zero");
        do_txn(16'h1234, 3'b000, 4'd7, 16'h1234, 1'b0, 0, 0, "pass_a7");
        do_txn(16'h1234, 3'b110, 4'd7, 16'h1234, 1'b0, 0, 0, "rsvd110_a7");
        do_txn(16'hF0CF, 3'b010, 4'd4, 16'h0F0C, 1'b1, 4, 3, "lsr_hold3");
        do_txn(16'h8001, 3'b100, 4'd2, 16'h0006, 1'b0, 2, 0, "rol_b2b");

        // Reset in the middle of a 10-step shift.
        in_valid = 1'b1;
        in_data  = 16'hF0CF;
        in_mode  = 3'b001;
        in_amt   = 4'd10;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_vals", 32'({in_ready, out_valid, out_data, out_carry, out_zero}),
            32'({1'b1, 1'b0, 16'h0000, 1'b0, 1'b1}));
        @(posedge clk); #2;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        chk("midrst_no_valid", 32'(seen), 32'(0));
        do_txn(16'hA5A5, 3'b010, 4'd3, 16'h14B4, 1'b1, 3, 1, "post_rst");

        for (int i = 0; i < 40; i++) begin
            rd = W'($urandom);
            rm = 3'($urandom_range(0, 7));
            ra = AW'($urandom_range(0, 15));
            r  = ref_op(rd, rm, ra);
            do_txn(rd, rm, ra, r[W-1:0], r[W], eff_amt(rm, ra), $urandom_range(0, 2), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
